imem_fetch_sequencer: RTL

- Owns the single byte-wide port of the 1 KiB byte-addressable instruction memory and shares it between two requesters: the core fetch path and a program loader.
- A fetch reads four consecutive bytes over four cycles and assembles them little-endian into a 32-bit instruction, returned to the core over a valid/ack handshake.
- Loader writes are single-byte, single-cycle.
- Sits between the core's PC logic and the memory array, which has a combinational read and a synchronous write.

---
 rtl/imem_fetch_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/imem_fetch_sequencer.sv
// Arbitrates the byte-wide instruction memory port between the core fetch path
// (4-beat little-endian assembly) and a loader. Optional halt detection: IMEM_HALT_DETECT_EN.
module imem_fetch_sequencer #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [63:0]       fetch_pc,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic              instr_fault,
    input  logic              instr_ack,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              halt_seen
);

    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

    state_t            state;
    logic [1:0]        beat;
    logic              last_fetch;   // 1: fetch won the previous grant
    logic [63:0]       pc_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;

    logic        in_idle, fetch_pend, ld_fire, fetch_fire, in_range;
    logic [64:0] beat_addr;
    logic [7:0]  rd_byte;

    // 65-bit sum so a pc near 2^64 can never wrap back into range
    assign beat_addr  = {1'b0, pc_q} + 65'(beat);
    assign in_range   = beat_addr < 65'(DEPTH);
    assign rd_byte    = in_range ? mem_rdata : 8'h00;

    assign in_idle    = (state == IDLE) && rst_n;
    assign fetch_pend = fetch_req && !halt_seen;
    assign fetch_ready = in_idle && fetch_pend && (!ld_valid || !last_fetch);
    assign ld_ready    = in_idle && ld_valid && (!fetch_pend || last_fetch);
    assign ld_fire     = ld_valid && ld_ready;
    assign fetch_fire  = fetch_req && fetch_ready;

    assign mem_we    = ld_fire;
    assign mem_wdata = ld_fire ? ld_data : wdata_q;
    always_comb begin
        mem_addr = addr_q;
        if (ld_fire)
            mem_addr = ld_addr;
        else if (state == FETCH && in_range)
            mem_addr = beat_addr[ADDR_W-1:0];
    end

`ifndef IMEM_HALT_DETECT_EN
    assign halt_seen = 1'b0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            halt_seen <= 1'b0;
        else if (state == FETCH && beat == 2'd3 && {rd_byte, instr[23:0]} == 32'h0000007F)
            halt_seen <= 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            beat        <= 2'd0;
            last_fetch  <= 1'b0;
            pc_q        <= 64'd0;
            addr_q      <= '0;
            wdata_q     <= 8'h00;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            instr_fault <= 1'b0;
        end else begin
            addr_q <= mem_addr;
            if (ld_fire)
                wdata_q <= ld_data;
            case (state)
                IDLE: begin
                    if (fetch_fire) begin
                        pc_q        <= fetch_pc;
                        beat        <= 2'd0;
                        instr_fault <= 1'b0;
                        last_fetch  <= 1'b1;
                        state       <= FETCH;
                    end else if (ld_fire) begin
                        last_fetch <= 1'b0;
                    end
                end
                FETCH: begin
                    instr[{beat, 3'b000} +: 8] <= rd_byte;
                    if (!in_range)
                        instr_fault <= 1'b1;
                    beat <= beat + 2'd1;
                    if (beat == 2'd3) begin
                        instr_valid <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (instr_ack) begin
                        instr_valid <= 1'b0;
                        instr_fault <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
